kugelblitz_capture: RTL and testbench

//  Passive tap on one 512-bit Ethernet AXI-stream port. Extracts 4 bytes at a software-set offset from the first beat of each frame.

---
 rtl/kugelblitz_capture_pkg.sv | 44 ++++
 rtl/kugelblitz_capture_if.sv | 54 +++++
 rtl/kugelblitz_capture_fifo.sv | 65 ++++++
 rtl/kugelblitz_capture.sv | 179 +++++++++++++++++
 tb/tb_kugelblitz_capture.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/kugelblitz_capture_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// kugelblitz_capture_pkg : register map, field positions, byte-extract helper
// rev 1.0
// ---------------------------------------------------------------------------
package kugelblitz_capture_pkg;

  localparam int AXIS_DW  = 512;
  localparam int AXIS_KW  = AXIS_DW / 8;
  localparam int AXIL_DW  = 32;
  localparam int AXIL_AW  = 32;
  localparam int AXIL_SW  = AXIL_DW / 8;

  typedef enum logic [2:0] {
    REG_CTRL   = 3'd0,
    REG_OFFSET = 3'd1,
    REG_STATUS = 3'd2,
    REG_FRAMES = 3'd3,
    REG_DATA   = 3'd4,
    REG_DROPS  = 3'd5
  } reg_sel_e;

  localparam int CTRL_ENABLE_BIT  = 0;
  localparam int CTRL_CLEAR_BIT   = 1;
  localparam int STATUS_COUNT_W   = 16;
  localparam int STATUS_OVF_BIT   = 16;
  localparam int STATUS_EMPTY_BIT = 17;

  // idx may run past the last lane (offset 63 + 3); such bytes read as zero
  function automatic logic [7:0] extract_byte(
    input logic [AXIS_DW-1:0] data,
    input logic [AXIS_KW-1:0] keep,
    input logic [6:0]         idx
  );
    logic [7:0] result;
    result = 8'h00;
    if (!idx[6] && keep[idx[5:0]]) begin
      result = data[{idx[5:0], 3'b000} +: 8];
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/kugelblitz_capture_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// kugelblitz_capture_if : tapped AXI-stream plus AXI-lite slave bundle
// rev 1.0
// ---------------------------------------------------------------------------
interface kugelblitz_capture_if;
  import kugelblitz_capture_pkg::*;

  logic [AXIS_DW-1:0] s_axis_tdata;
  logic [AXIS_KW-1:0] s_axis_tkeep;
  logic               s_axis_tvalid;
  logic               s_axis_tready;
  logic               s_axis_tlast;

  logic [AXIL_AW-1:0] s_axil_awaddr;
  logic [2:0]         s_axil_awprot;
  logic               s_axil_awvalid;
  logic               s_axil_awready;
  logic [AXIL_DW-1:0] s_axil_wdata;
  logic [AXIL_SW-1:0] s_axil_wstrb;
  logic               s_axil_wvalid;
  logic               s_axil_wready;
  logic [1:0]         s_axil_bresp;
  logic               s_axil_bvalid;
  logic               s_axil_bready;
  logic [AXIL_AW-1:0] s_axil_araddr;
  logic [2:0]         s_axil_arprot;
  logic               s_axil_arvalid;
  logic               s_axil_arready;
  logic [AXIL_DW-1:0] s_axil_rdata;
  logic [1:0]         s_axil_rresp;
  logic               s_axil_rvalid;
  logic               s_axil_rready;

  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tready, s_axis_tlast,
    output s_axil_awaddr, s_axil_awprot, s_axil_awvalid, s_axil_wdata, s_axil_wstrb,
    output s_axil_wvalid, s_axil_bready, s_axil_araddr, s_axil_arprot, s_axil_arvalid,
    output s_axil_rready,
    input  s_axil_awready, s_axil_wready, s_axil_bresp, s_axil_bvalid,
    input  s_axil_arready, s_axil_rdata, s_axil_rresp, s_axil_rvalid
  );

  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tready, s_axis_tlast,
    input  s_axil_awaddr, s_axil_awprot, s_axil_awvalid, s_axil_wdata, s_axil_wstrb,
    input  s_axil_wvalid, s_axil_bready, s_axil_araddr, s_axil_arprot, s_axil_arvalid,
    input  s_axil_rready,
    output s_axil_awready, s_axil_wready, s_axil_bresp, s_axil_bvalid,
    output s_axil_arready, s_axil_rdata, s_axil_rresp, s_axil_rvalid
  );

endinterface
`default_nettype wire

// File: rtl/kugelblitz_capture_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// kugelblitz_capture_fifo : synchronous first-word-fall-through FIFO with flush
// rev 1.0
// ---------------------------------------------------------------------------
module kugelblitz_capture_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     push,
  input  wire logic [WIDTH-1:0]         push_data,
  input  wire logic                     pop,
  input  wire logic                     flush,
  output logic      [$clog2(DEPTH):0]   count,
  output logic                          full,
  output logic                          empty,
  output logic      [WIDTH-1:0]         head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign empty     = (r_count == '0);
  assign full      = (r_count == FULL_CNT);
  assign count     = r_count;
  assign head      = r_mem[r_rd_ptr];
  // a pop in the same cycle frees the slot a full-FIFO push needs
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/kugelblitz_capture.sv
`default_nettype none
// ---------------------------------------------------------------------------
// kugelblitz_capture : passive AXI-stream tap capturing 4 bytes per frame
// rev 1.0
// ---------------------------------------------------------------------------
module kugelblitz_capture
  import kugelblitz_capture_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = 512,
  parameter int AXIS_KEEP_WIDTH = 64,
  parameter int AXIL_DATA_WIDTH = 32,
  parameter int AXIL_ADDR_WIDTH = 32,
  parameter int AXIL_STRB_WIDTH = 4,
  parameter int FIFO_DEPTH      = 16
) (
  input wire logic            clk,
  input wire logic            rst,
  kugelblitz_capture_if.slave bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  generate
    if (AXIS_DATA_WIDTH != AXIS_DW || AXIS_KEEP_WIDTH != AXIS_KW ||
        AXIL_DATA_WIDTH != AXIL_DW || AXIL_ADDR_WIDTH != AXIL_AW ||
        AXIL_STRB_WIDTH != AXIL_SW) begin : g_bad_width
      $error("kugelblitz_capture: only 512-bit stream and 32-bit AXI-lite are supported");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        FIFO_DEPTH > 32768) begin : g_bad_depth
      $error("kugelblitz_capture: FIFO_DEPTH must be a power of 2 in 2..32768");
    end
  endgenerate

  logic             r_enable;
  logic [5:0]       r_offset;
  logic             r_overflow;
  logic [31:0]      r_frames;
  logic [31:0]      r_drops;
  logic             r_sof;
  logic             r_bvalid;
  logic             r_rvalid;
  logic [31:0]      r_rdata;

  logic             w_wr_hs;
  logic             w_rd_hs;
  logic [2:0]       w_wr_sel;
  logic [2:0]       w_rd_sel;
  logic             w_clear;
  logic             w_accept;
  logic             w_capture;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [31:0]      w_word;
  logic [31:0]      w_rd_mux;
  logic [CNT_W-1:0] w_count;
  logic             w_full;
  logic             w_empty;
  logic [31:0]      w_head;
  logic             w_unused_bits;

  assign w_wr_hs   = bus.s_axil_awvalid & bus.s_axil_wvalid & ~r_bvalid;
  assign w_rd_hs   = bus.s_axil_arvalid & ~r_rvalid;
  assign w_wr_sel  = bus.s_axil_awaddr[4:2];
  assign w_rd_sel  = bus.s_axil_araddr[4:2];
  assign w_clear   = w_wr_hs & (w_wr_sel == REG_CTRL) & bus.s_axil_wdata[CTRL_CLEAR_BIT];
  assign w_accept  = bus.s_axis_tvalid & bus.s_axis_tready;
  assign w_capture = w_accept & r_sof & r_enable;
  assign w_pop     = w_rd_hs & (w_rd_sel == REG_DATA) & ~w_empty;
  assign w_push    = w_capture & (~w_full | w_pop);
  assign w_drop    = w_capture & w_full & ~w_pop;

  assign w_unused_bits = ^{bus.s_axil_awaddr[31:5], bus.s_axil_awaddr[1:0],
                           bus.s_axil_araddr[31:5], bus.s_axil_araddr[1:0],
                           bus.s_axil_wdata[31:6], bus.s_axil_wstrb,
                           bus.s_axil_awprot, bus.s_axil_arprot};

  generate
    for (genvar j = 0; j < 4; j++) begin : g_byte
      assign w_word[8*j +: 8] = extract_byte(bus.s_axis_tdata, bus.s_axis_tkeep,
                                             {1'b0, r_offset} + 7'(j));
    end
  endgenerate

  kugelblitz_capture_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_word),
    .pop       (w_pop),
    .flush     (w_clear),
    .count     (w_count),
    .full      (w_full),
    .empty     (w_empty),
    .head      (w_head)
  );

  always_comb begin
    w_rd_mux = '0;
    case (w_rd_sel)
      REG_CTRL:   w_rd_mux[CTRL_ENABLE_BIT] = r_enable;
      REG_OFFSET: w_rd_mux[5:0] = r_offset;
      REG_STATUS: begin
        w_rd_mux[STATUS_COUNT_W-1:0] = STATUS_COUNT_W'(w_count);
        w_rd_mux[STATUS_OVF_BIT]     = r_overflow;
        w_rd_mux[STATUS_EMPTY_BIT]   = w_empty;
      end
      REG_FRAMES: w_rd_mux = r_frames;
      REG_DATA:   w_rd_mux = w_empty ? 32'h0 : w_head;
      REG_DROPS:  w_rd_mux = r_drops;
      default:    w_rd_mux = '0;
    endcase
  end

  // clear outranks any same-cycle frame, drop or sof update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_enable   <= 1'b0;
      r_offset   <= '0;
      r_overflow <= 1'b0;
      r_frames   <= '0;
      r_drops    <= '0;
      r_sof      <= 1'b1;
    end else begin
      if (w_wr_hs) begin
        case (w_wr_sel)
          REG_CTRL:   r_enable <= bus.s_axil_wdata[CTRL_ENABLE_BIT];
          REG_OFFSET: r_offset <= bus.s_axil_wdata[5:0];
          default:    ;
        endcase
      end
      if (w_clear) begin
        r_sof      <= 1'b1;
        r_frames   <= '0;
        r_drops    <= '0;
        r_overflow <= 1'b0;
      end else begin
        if (w_accept) r_sof <= bus.s_axis_tlast;
        if (w_accept && bus.s_axis_tlast && r_enable) r_frames <= r_frames + 32'd1;
        if (w_drop) begin
          r_drops    <= r_drops + 32'd1;
          r_overflow <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bvalid <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      if (w_wr_hs) r_bvalid <= 1'b1;
      else if (bus.s_axil_bready) r_bvalid <= 1'b0;
      if (w_rd_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_mux;
      end else if (bus.s_axil_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign bus.s_axil_awready = w_wr_hs;
  assign bus.s_axil_wready  = w_wr_hs;
  assign bus.s_axil_bresp   = 2'b00;
  assign bus.s_axil_bvalid  = r_bvalid;
  assign bus.s_axil_arready = w_rd_hs;
  assign bus.s_axil_rdata   = r_rdata;
  assign bus.s_axil_rresp   = 2'b00;
  assign bus.s_axil_rvalid  = r_rvalid;

endmodule
`default_nettype wire

// File: tb/tb_kugelblitz_capture.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_kugelblitz_capture : randomized self-checking bench with queue model
// rev 1.0
// ---------------------------------------------------------------------------
module tb_kugelblitz_capture;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  kugelblitz_capture_if bus ();

  kugelblitz_capture #(.FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // reference model state
  bit [31:0]   m_q[$];
  int unsigned m_frames;
  int unsigned m_drops;
  bit          m_ovf;
  bit          m_sof;
  bit          m_en;
  int          m_off;

  function automatic bit [31:0] model_word(bit [511:0] d, bit [63:0] k, int off);
    bit [31:0] w;
    w = 32'h0;
    for (int j = 0; j < 4; j++) begin
      if (off + j <= 63 && k[off + j]) w[8*j +: 8] = d[8*(off + j) +: 8];
    end
    return w;
  endfunction

  function automatic bit [31:0] m_status();
    return {14'd0, m_q.size() == 0, m_ovf, 16'(m_q.size())};
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_frames = 0;
    m_drops  = 0;
    m_ovf    = 1'b0;
    m_sof    = 1'b1;
  endtask

  task automatic model_accept(bit [511:0] d, bit [63:0] k, bit last);
    if (m_sof && m_en) begin
      if (m_q.size() < DEPTH) m_q.push_back(model_word(d, k, m_off));
      else begin
        m_drops++;
        m_ovf = 1'b1;
      end
    end
    if (last && m_en) m_frames++;
    m_sof = last;
  endtask

  function automatic bit [511:0] ramp_data();
    bit [511:0] d;
    for (int n = 0; n < 64; n++) d[8*n +: 8] = 8'(n);
    return d;
  endfunction

  function automatic bit [511:0] rand_data();
    bit [511:0] d;
    for (int n = 0; n < 16; n++) d[32*n +: 32] = $urandom;
    return d;
  endfunction

  function automatic bit [63:0] rand_keep();
    bit [63:0] k;
    k = {$urandom, $urandom};
    if ($urandom_range(0, 1) == 1) k = '1;
    return k;
  endfunction

  task automatic drive_idle();
    bus.s_axis_tdata   = '0;
    bus.s_axis_tkeep   = '0;
    bus.s_axis_tvalid  = 1'b0;
    bus.s_axis_tready  = 1'b0;
    bus.s_axis_tlast   = 1'b0;
    bus.s_axil_awaddr  = '0;
    bus.s_axil_awprot  = '0;
    bus.s_axil_awvalid = 1'b0;
    bus.s_axil_wdata   = '0;
    bus.s_axil_wstrb   = 4'hF;
    bus.s_axil_wvalid  = 1'b0;
    bus.s_axil_bready  = 1'b1;
    bus.s_axil_araddr  = '0;
    bus.s_axil_arprot  = '0;
    bus.s_axil_arvalid = 1'b0;
    bus.s_axil_rready  = 1'b1;
  endtask

  // all bus tasks start and end on a falling edge
  task automatic axil_write(input bit [31:0] a, input bit [31:0] d, input bit brdy);
    int n;
    n = 0;
    bus.s_axil_awaddr  = a;
    bus.s_axil_wdata   = d;
    bus.s_axil_awvalid = 1'b1;
    bus.s_axil_wvalid  = 1'b1;
    bus.s_axil_bready  = brdy;
    #1;
    while (bus.s_axil_awready !== 1'b1 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 20) begin
      errors++;
      $display("FAIL write_timeout addr %h got no awready required awready within 20 cycles", a);
    end
    @(negedge clk);
    bus.s_axil_awvalid = 1'b0;
    bus.s_axil_wvalid  = 1'b0;
  endtask

  task automatic axil_read(input bit [31:0] a, output bit [31:0] d, input bit rrdy);
    int n;
    n = 0;
    bus.s_axil_araddr  = a;
    bus.s_axil_arvalid = 1'b1;
    bus.s_axil_rready  = rrdy;
    #1;
    while (bus.s_axil_arready !== 1'b1 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 20) begin
      errors++;
      $display("FAIL read_timeout addr %h got no arready required arready within 20 cycles", a);
    end
    @(negedge clk);
    bus.s_axil_arvalid = 1'b0;
    d = bus.s_axil_rdata;
  endtask

  task automatic csr_write(input bit [31:0] a, input bit [31:0] d);
    axil_write(a, d, 1'b1);
    if (a[4:2] == 3'd0) begin
      m_en = d[0];
      if (d[1]) model_clear();
    end else if (a[4:2] == 3'd1) begin
      m_off = int'(d[5:0]);
    end
  endtask

  task automatic beat(input bit [511:0] d, input bit [63:0] k, input bit last, input int stalls);
    bus.s_axis_tdata  = d;
    bus.s_axis_tkeep  = k;
    bus.s_axis_tlast  = last;
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tready = 1'b0;
    repeat (stalls) @(negedge clk);
    bus.s_axis_tready = 1'b1;
    model_accept(d, k, last);
    @(negedge clk);
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tready = 1'b0;
  endtask

  task automatic test_reset();
    logic [71:0] outs;
    bit [31:0]   got;
    drive_idle();
    model_clear();
    m_en  = 1'b0;
    m_off = 0;
    repeat (2) @(negedge clk);
    outs = {bus.s_axil_awready, bus.s_axil_wready, bus.s_axil_bresp, bus.s_axil_bvalid,
            bus.s_axil_arready, bus.s_axil_rdata, bus.s_axil_rresp, bus.s_axil_rvalid, 29'd0};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_outputs got %h required 0", outs); end
    rst = 1'b0;
    @(negedge clk);
    axil_read(32'h08, got, 1'b1);
    checks++;
    if (got !== 32'h0002_0000) begin errors++; $display("FAIL reset_status got %h required %h", got, 32'h0002_0000); end
    axil_read(32'h00, got, 1'b1);
    checks++;
    if (got !== 32'h0) begin errors++; $display("FAIL reset_ctrl got %h required 0", got); end
    axil_read(32'h04, got, 1'b1);
    checks++;
    if (got !== 32'h0) begin errors++; $display("FAIL reset_offset got %h required 0", got); end
  endtask

  task automatic test_basic();
    bit [31:0] got;
    csr_write(32'h04, 32'd12);
    csr_write(32'h00, 32'd1);
    beat(ramp_data(), '1, 1'b0, 0);
    beat(rand_data(), '1, 1'b0, 0);
    beat(rand_data(), '1, 1'b1, 0);
    axil_read(32'h08, got, 1'b1);
    checks++;
    if (got !== 32'h0000_0001) begin errors++; $display("FAIL basic_status1 got %h required %h", got, 32'h1); end
    axil_read(32'h10, got, 1'b1);
    void'(m_q.pop_front());
    checks++;
    if (got !== 32'h0F0E_0D0C) begin errors++; $display("FAIL basic_data got %h required %h", got, 32'h0F0E0D0C); end
    axil_read(32'h0C, got, 1'b1);
    checks++;
    if (got !== 32'd1) begin errors++; $display("FAIL basic_frames got %h required 1", got); end
    axil_read(32'h08, got, 1'b1);
    checks++;
    if (got !== 32'h0002_0000) begin errors++; $display("FAIL basic_status0 got %h required %h", got, 32'h0002_0000); end
  endtask

  task automatic test_offset_edge();
    bit [31:0] got;
    bit [63:0] k;
    csr_write(32'h04, 32'd62);
    beat(ramp_data(), '1, 1'b1, 0);
    axil_read(32'h10, got, 1'b1);
    void'(m_q.pop_front());
    checks++;
    if (got !== 32'h0000_3F3E) begin errors++; $display("FAIL edge62_keepall got %h required %h", got, 32'h3F3E); end
    k = '1;
    k[63] = 1'b0;
    beat(ramp_data(), k, 1'b1, 0);
    axil_read(32'h10, got, 1'b1);
    void'(m_q.pop_front());
    checks++;
    if (got !== 32'h0000_003E) begin errors++; $display("FAIL edge62_keep63off got %h required %h", got, 32'h3E); end
    csr_write(32'h04, 32'd63);
    beat(ramp_data(), '1, 1'b1, 0);
    axil_read(32'h10, got, 1'b1);
    void'(m_q.pop_front());
    checks++;
    if (got !== 32'h0000_003F) begin errors++; $display("FAIL edge63 got %h required %h", got, 32'h3F); end
  endtask

  task automatic test_overflow();
    bit [31:0] got;
    bit [31:0] exp;
    csr_write(32'h00, 32'h3);
    csr_write(32'h04, 32'd0);
    for (int f = 0; f < 18; f++) beat(rand_data(), '1, 1'b1, 0);
    axil_read(32'h08, got, 1'b1);
    checks++;
    if (got !== 32'h0001_0010) begin errors++; $display("FAIL ovf_status got %h required %h", got, 32'h0001_0010); end
    axil_read(32'h14, got, 1'b1);
    checks++;
    if (got !== 32'd2) begin errors++; $display("FAIL ovf_drops got %h required 2", got); end
    axil_read(32'h0C, got, 1'b1);
    checks++;
    if (got !== 32'd18) begin errors++; $display("FAIL ovf_frames got %h required 18", got); end
    for (int r = 0; r < 16; r++) begin
      axil_read(32'h10, got, 1'b1);
      exp = m_q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL ovf_drain%0d got %h required %h", r, got, exp); end
    end
    axil_read(32'h10, got, 1'b1);
    checks++;
    if (got !== 32'h0) begin errors++; $display("FAIL ovf_empty_read got %h required 0", got); end
    axil_read(32'h08, got, 1'b1);
    checks++;
    if (got !== 32'h0003_0000) begin errors++; $display("FAIL ovf_status_after got %h required %h", got, 32'h0003_0000); end
  endtask

  task automatic test_full_push_pop_and_clear();
    bit [31:0]  got;
    bit [31:0]  exp;
    bit [511:0] d;
    csr_write(32'h00, 32'h3);
    for (int f = 0; f < DEPTH; f++) beat(rand_data(), '1, 1'b1, 0);
    @(negedge clk);
    // DATA read and a capturing beat land on the same clock edge
    d = rand_data();
    exp = m_q.pop_front();
    bus.s_axil_araddr  = 32'h10;
    bus.s_axil_arvalid = 1'b1;
    bus.s_axis_tdata   = d;
    bus.s_axis_tkeep   = '1;
    bus.s_axis_tlast   = 1'b1;
    bus.s_axis_tvalid  = 1'b1;
    bus.s_axis_tready  = 1'b1;
    model_accept(d, '1, 1'b1);
    #1;
    checks++;
    if (bus.s_axil_arready !== 1'b1) begin errors++; $display("FAIL pushpop_arready got %b required 1", bus.s_axil_arready); end
    @(negedge clk);
    bus.s_axil_arvalid = 1'b0;
    bus.s_axis_tvalid  = 1'b0;
    bus.s_axis_tready  = 1'b0;
    got = bus.s_axil_rdata;
    checks++;
    if (got !== exp) begin errors++; $display("FAIL pushpop_data got %h required %h", got, exp); end
    axil_read(32'h08, got, 1'b1);
    checks++;
    if (got !== m_status()) begin errors++; $display("FAIL pushpop_status got %h required %h", got, m_status()); end
    axil_read(32'h14, got, 1'b1);
    checks++;
    if (got !== 32'd0) begin errors++; $display("FAIL pushpop_drops got %h required 0", got); end
    beat(rand_data(), '1, 1'b0, 0);
    @(negedge clk);
    // clear write alongside a DATA read: read returns the pre-clear head
    exp = m_q[0];
    bus.s_axil_awaddr  = 32'h00;
    bus.s_axil_wdata   = 32'h3;
    bus.s_axil_awvalid = 1'b1;
    bus.s_axil_wvalid  = 1'b1;
    bus.s_axil_araddr  = 32'h10;
    bus.s_axil_arvalid = 1'b1;
    model_clear();
    @(negedge clk);
    bus.s_axil_awvalid = 1'b0;
    bus.s_axil_wvalid  = 1'b0;
    bus.s_axil_arvalid = 1'b0;
    got = bus.s_axil_rdata;
    checks++;
    if (got !== exp) begin errors++; $display("FAIL clear_read_head got %h required %h", got, exp); end
    axil_read(32'h08, got, 1'b1);
    checks++;
    if (got !== 32'h0002_0000) begin errors++; $display("FAIL clear_status got %h required %h", got, 32'h0002_0000); end
    axil_read(32'h0C, got, 1'b1);
    checks++;
    if (got !== 32'd0) begin errors++; $display("FAIL clear_frames got %h required 0", got); end
    d = rand_data();
    beat(d, '1, 1'b0, 0);
    beat(rand_data(), '1, 1'b1, 0);
    axil_read(32'h10, got, 1'b1);
    exp = m_q.pop_front();
    checks++;
    if (got !== model_word(d, '1, m_off)) begin errors++; $display("FAIL clear_sof_capture got %h required %h", got, model_word(d, '1, m_off)); end
  endtask

  task automatic test_disable_stall();
    bit [31:0]   got;
    bit [31:0]   exp;
    int unsigned frames_before;
    csr_write(32'h00, 32'h0);
    frames_before = m_frames;
    for (int f = 0; f < 2; f++) begin
      beat(rand_data(), '1, 1'b0, 0);
      beat(rand_data(), '1, 1'b1, 0);
    end
    axil_read(32'h0C, got, 1'b1);
    checks++;
    if (got !== frames_before) begin errors++; $display("FAIL disabled_frames got %h required %h", got, frames_before); end
    axil_read(32'h08, got, 1'b1);
    checks++;
    if (got !== 32'h0002_0000) begin errors++; $display("FAIL disabled_status got %h required %h", got, 32'h0002_0000); end
    csr_write(32'h00, 32'h1);
    csr_write(32'h04, 32'd5);
    beat(rand_data(), rand_keep(), 1'b0, 3);
    beat(rand_data(), rand_keep(), 1'b0, 2);
    beat(rand_data(), rand_keep(), 1'b1, 1);
    axil_read(32'h08, got, 1'b1);
    checks++;
    if (got !== 32'h0000_0001) begin errors++; $display("FAIL stall_status got %h required 1", got); end
    axil_read(32'h10, got, 1'b1);
    exp = m_q.pop_front();
    checks++;
    if (got !== exp) begin errors++; $display("FAIL stall_data got %h required %h", got, exp); end
  endtask

  task automatic test_random();
    bit [31:0] got;
    bit [31:0] exp;
    int        len;
    csr_write(32'h00, 32'h3);
    for (int it = 0; it < 48; it++) begin
      if ($urandom_range(0, 3) == 0) csr_write(32'h04, 32'($urandom_range(0, 63)));
      if ($urandom_range(0, 7) == 0) csr_write(32'h00, {31'd0, $urandom_range(0, 3) != 0});
      len = int'($urandom_range(1, 3));
      for (int b = 0; b < len; b++) beat(rand_data(), rand_keep(), b == len - 1, int'($urandom_range(0, 2)));
      if ($urandom_range(0, 2) != 0) begin
        axil_read(32'h10, got, 1'b1);
        exp = (m_q.size() != 0) ? m_q.pop_front() : 32'h0;
        checks++;
        if (got !== exp) begin errors++; $display("FAIL rand_data it%0d got %h required %h", it, got, exp); end
      end
    end
    axil_read(32'h08, got, 1'b1);
    checks++;
    if (got !== m_status()) begin errors++; $display("FAIL rand_status got %h required %h", got, m_status()); end
    axil_read(32'h0C, got, 1'b1);
    checks++;
    if (got !== m_frames) begin errors++; $display("FAIL rand_frames got %h required %h", got, m_frames); end
    axil_read(32'h14, got, 1'b1);
    checks++;
    if (got !== m_drops) begin errors++; $display("FAIL rand_drops got %h required %h", got, m_drops); end
  endtask

  task automatic test_async_reset();
    bit [31:0]   got;
    logic [71:0] outs;
    csr_write(32'h00, 32'h1);
    beat(rand_data(), '1, 1'b0, 0);
    axil_write(32'h04, 32'd7, 1'b0);
    axil_read(32'h00, got, 1'b0);
    checks++;
    if ({bus.s_axil_bvalid, bus.s_axil_rvalid, bus.s_axil_rdata} !== {2'b11, 32'h1}) begin
      errors++;
      $display("FAIL pending_resp got %b %b %h required 1 1 1", bus.s_axil_bvalid, bus.s_axil_rvalid, bus.s_axil_rdata);
    end
    #2;
    rst = 1'b1;
    #1;
    outs = {bus.s_axil_awready, bus.s_axil_wready, bus.s_axil_bresp, bus.s_axil_bvalid,
            bus.s_axil_arready, bus.s_axil_rdata, bus.s_axil_rresp, bus.s_axil_rvalid, 29'd0};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL async_reset_outputs got %h required 0", outs); end
    model_clear();
    m_en  = 1'b0;
    m_off = 0;
    bus.s_axil_bready = 1'b1;
    bus.s_axil_rready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    axil_read(32'h18, got, 1'b1);
    checks++;
    if ({got, bus.s_axil_rresp} !== 34'h0) begin errors++; $display("FAIL unmapped_read got %h resp %b required 0 00", got, bus.s_axil_rresp); end
    axil_read(32'h04, got, 1'b1);
    checks++;
    if (got !== 32'h0) begin errors++; $display("FAIL post_reset_offset got %h required 0", got); end
    csr_write(32'h00, 32'h1);
    beat(ramp_data(), '1, 1'b0, 0);
    axil_read(32'h10, got, 1'b1);
    checks++;
    if (got !== 32'h0302_0100) begin errors++; $display("FAIL post_reset_sof got %h required %h", got, 32'h03020100); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_offset_edge();
    test_overflow();
    test_full_push_pop_and_clear();
    test_disable_stall();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got running required finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
